// File: rtl/pfpu_vscan_if.sv
// Sequencer/CSR-side bundle of the PFPU vertex scanner.
// The master modport is the sequencer and CSR block; the slave is the scanner.
interface pfpu_vscan_if #(
  parameter int XW = 7,
  parameter int AW = 29
);
  logic [XW-1:0]   hmesh_last;
  logic [XW-1:0]   vmesh_last;
  logic [AW-1:0]   dma_base;
  logic            vfirst;
  logic            vnext;
  logic            busy;
  logic [XW-1:0]   vx;
  logic [XW-1:0]   vy;
  logic            vlast;
  logic [AW-1:0]   dma_adr;
  logic [2*XW:0]   vertex_count;
  logic [2*XW:0]   last_count;
  logic            irq;

  modport master (
    output hmesh_last, vmesh_last, dma_base, vfirst, vnext, busy,
    input  vx, vy, vlast, dma_adr, vertex_count, last_count, irq
  );

  modport slave (
    input  hmesh_last, vmesh_last, dma_base, vfirst, vnext, busy,
    output vx, vy, vlast, dma_adr, vertex_count, last_count, irq
  );
endinterface

// File: rtl/pfpu_vscan.sv
// Vertex mesh scanner and DMA address generator for the PFPU.
// Walks (vx, vy) row by row under vfirst/vnext and pulses irq when busy falls.
module pfpu_vscan #(
  parameter int XW = 7,
  parameter int AW = 29
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  pfpu_vscan_if.slave  bus
);
  localparam int CW = 2*XW + 1;

  logic [XW-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [XW-1:0] hl_q, hl_d, vl_q, vl_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d, last_q, last_d;
  logic          busy_dly_q, busy_dly_d;
  logic          irq_q, irq_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    vx_d       = vx_q;
    vy_d       = vy_q;
    hl_d       = hl_q;
    vl_d       = vl_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    busy_dly_d = bus.busy;
    irq_d      = busy_dly_q & ~bus.busy;
    last_d     = last_q;

    // Configuration is sampled only at rewind, so CSR writes mid-run are harmless.
    if (bus.vfirst) begin
      hl_d   = bus.hmesh_last;
      vl_d   = bus.vmesh_last;
      base_d = bus.dma_base;
      vx_d   = '0;
      vy_d   = '0;
      cnt_d  = '0;
    end else if (bus.vnext) begin
      if (vx_q != hl_q) begin
        vx_d = vx_q + XW'(1);
      end else begin
        vx_d = '0;
        vy_d = (vy_q != vl_q) ? vy_q + XW'(1) : '0;
      end
      if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
    end

    if (irq_d) last_d = cnt_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (sys_rst) begin
      vx_q       <= '0;
      vy_q       <= '0;
      hl_q       <= '0;
      vl_q       <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      busy_dly_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      hl_q       <= hl_d;
      vl_q       <= vl_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      busy_dly_q <= busy_dly_d;
      irq_q      <= irq_d;
    end
  end

  // vlast must be combinational: the sequencer samples it in the cycle it strobes vnext.
  assign bus.vx           = vx_q;
  assign bus.vy           = vy_q;
  assign bus.vlast        = (vx_q == hl_q) && (vy_q == vl_q);
  assign bus.dma_adr      = base_q + AW'({vy_q, vx_q, 1'b0});
  assign bus.vertex_count = cnt_q;
  assign bus.last_count   = last_q;
  assign bus.irq          = irq_q;
endmodule

// File: tb/tb_pfpu_vscan.sv
// Self-checking bench for pfpu_vscan: a linear-index mesh model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_pfpu_vscan;
  localparam int XW = 7;
  localparam int AW = 29;
  localparam int CW = 2*XW + 1;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  pfpu_vscan_if #(.XW(XW), .AW(AW)) bus ();

  pfpu_vscan #(.XW(XW), .AW(AW)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;
  int irq_pulses = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the scan position is a linear index into a W x H mesh.
  longint m_idx = 0, m_hl = 0, m_vl = 0, m_base = 0, m_cnt = 0, m_last = 0;
  bit     m_busy_prev = 1'b0, m_irq = 1'b0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_idx = 0; m_hl = 0; m_vl = 0; m_base = 0; m_cnt = 0; m_last = 0;
      m_busy_prev = 1'b0; m_irq = 1'b0;
    end else begin
      m_irq = m_busy_prev && !bus.busy;
      if (m_irq) m_last = m_cnt;
      m_busy_prev = bus.busy;
      if (bus.vfirst) begin
        m_hl = bus.hmesh_last; m_vl = bus.vmesh_last; m_base = bus.dma_base;
        m_idx = 0; m_cnt = 0;
      end else if (bus.vnext) begin
        m_idx = (m_idx + 1) % ((m_hl + 1) * (m_vl + 1));
        m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
      end
    end
  end

  always @(negedge sys_clk) begin
    longint ex, ey, ea;
    if (cmp_en) begin
      ex = m_idx % (m_hl + 1);
      ey = m_idx / (m_hl + 1);
      ea = (m_base + ey * (1 << (XW + 1)) + 2 * ex) % (64'd1 << AW);
      check("vx", 64'(bus.vx), ex);
      check("vy", 64'(bus.vy), ey);
      check("vlast", 64'(bus.vlast), (m_idx == (m_hl + 1) * (m_vl + 1) - 1) ? 1 : 0);
      check("dma_adr", 64'(bus.dma_adr), ea);
      check("vertex_count", 64'(bus.vertex_count), m_cnt);
      check("last_count", 64'(bus.last_count), m_last);
      check("irq", 64'(bus.irq), 64'(m_irq));
      if (bus.irq) irq_pulses++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  logic [AW-1:0] exp_adr [6] = '{29'h1000, 29'h1002, 29'h1004, 29'h1100, 29'h1102, 29'h1104};
  logic [XW-1:0] exp_x   [6] = '{7'd0, 7'd1, 7'd2, 7'd0, 7'd1, 7'd2};
  logic [XW-1:0] exp_y   [6] = '{7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1};

  initial begin
    bus.hmesh_last = '0; bus.vmesh_last = '0; bus.dma_base = '0;
    bus.vfirst = 1'b0; bus.vnext = 1'b0; bus.busy = 1'b0;
    tick(); tick();
    sys_rst = 1'b0;
    cmp_en  = 1'b1;
    check("rst_vlast", 64'(bus.vlast), 64'd1);
    check("rst_adr", 64'(bus.dma_adr), 64'd0);

    // 3x2 scan with CSR changes after the rewind
    bus.hmesh_last = 7'd2; bus.vmesh_last = 7'd1; bus.dma_base = 29'h1000;
    bus.busy = 1'b1; bus.vfirst = 1'b1;
    tick();
    bus.vfirst = 1'b0;
    bus.hmesh_last = 7'd9; bus.dma_base = '0;
    for (int i = 0; i < 6; i++) begin
      check("scan_x", 64'(bus.vx), 64'(exp_x[i]));
      check("scan_y", 64'(bus.vy), 64'(exp_y[i]));
      check("scan_adr", 64'(bus.dma_adr), 64'(exp_adr[i]));
      check("scan_vlast", 64'(bus.vlast), (i == 5) ? 64'd1 : 64'd0);
      check("scan_cnt", 64'(bus.vertex_count), 64'(i));
      if (i < 5) begin
        bus.vnext = 1'b1; tick(); bus.vnext = 1'b0;
      end
    end

    // wrap from last vertex
    bus.vnext = 1'b1; tick(); bus.vnext = 1'b0;
    check("wrap_x", 64'(bus.vx), 64'd0);
    check("wrap_y", 64'(bus.vy), 64'd0);
    check("wrap_cnt", 64'(bus.vertex_count), 64'd6);

    // completion
    bus.busy = 1'b0; tick();
    check("irq_rise", 64'(bus.irq), 64'd1);
    check("last_count", 64'(bus.last_count), 64'd6);
    tick();
    check("irq_fall", 64'(bus.irq), 64'd0);
    repeat (10) tick();
    check("irq_pulses", 64'(irq_pulses), 64'd1);

    // vfirst beats vnext
    bus.hmesh_last = 7'd2; bus.dma_base = 29'h1000; bus.busy = 1'b1;
    bus.vnext = 1'b1; tick(); tick();
    bus.vfirst = 1'b1; tick();
    bus.vfirst = 1'b0; bus.vnext = 1'b0;
    check("prio_x", 64'(bus.vx), 64'd0);
    check("prio_cnt", 64'(bus.vertex_count), 64'd0);

    // asynchronous reset mid-cycle, mid-run
    bus.vnext = 1'b1; tick(); tick(); bus.vnext = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    check("arst_vx", 64'(bus.vx), 64'd0);
    check("arst_cnt", 64'(bus.vertex_count), 64'd0);
    check("arst_vlast", 64'(bus.vlast), 64'd1);
    check("arst_adr", 64'(bus.dma_adr), 64'd0);
    check("arst_last", 64'(bus.last_count), 64'd0);
    tick();
    sys_rst = 1'b0;
    bus.busy = 1'b0;
    tick();

    // 1x1 mesh and counter saturation
    bus.hmesh_last = '0; bus.vmesh_last = '0; bus.dma_base = 29'h0ABC;
    bus.busy = 1'b1; bus.vfirst = 1'b1; tick(); bus.vfirst = 1'b0;
    bus.vnext = 1'b1;
    repeat ((1 << 15) + 3) tick();
    bus.vnext = 1'b0;
    check("sat_cnt", 64'(bus.vertex_count), 64'h7FFF);
    check("sat_vlast", 64'(bus.vlast), 64'd1);
    check("sat_adr", 64'(bus.dma_adr), 64'h0ABC);
    bus.busy = 1'b0; tick();
    check("sat_last", 64'(bus.last_count), 64'h7FFF);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
